// File: rtl/iter_alu_if.sv
// Request/response bundle for the iterative ALU.
// The master drives requests and consumes results; the slave is the ALU.
interface iter_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;

    modport master (
        output in_valid, op, in_1, in_2, flush, out_ready,
        input  in_ready, out_valid, out, zero
    );

    modport slave (
        input  in_valid, op, in_1, in_2, flush, out_ready,
        output in_ready, out_valid, out, zero
    );
endinterface

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle basic ops, radix-2 shift-add multiply and
// restoring divide (one bit per cycle on operand magnitudes, sign applied
// in the last iteration). Result is held until the consumer takes it.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    iter_alu_if.slave bus
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHU  = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_a;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   r_b;      // multiplier / dividend-then-quotient shift register
    logic [WIDTH-1:0]   r_acc;    // product high half / partial remainder
    logic               r_neg;    // sign to apply to the final result
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_out;
    logic               r_zero;

    logic               w_accept;
    logic               w_iter_op;
    logic               w_div_op;
    logic               w_early;
    logic               w_start_busy;
    logic               w_last;
    logic               w_busy_mul;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_imm;
    logic               w_sa;
    logic               w_sb;
    logic               w_neg;
    logic [WIDTH-1:0]   w_mag_1;
    logic [WIDTH-1:0]   w_mag_2;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH-1:0]   w_macc;
    logic [WIDTH-1:0]   w_mmq;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_dsh;
    logic               w_dge;
    logic [WIDTH-1:0]   w_dsub;
    logic [WIDTH-1:0]   w_dacc;
    logic [WIDTH-1:0]   w_dq;
    logic [WIDTH-1:0]   w_fin;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out       = r_out;
    assign bus.zero      = r_zero;

    // Request decode: immediate result, early divide exits, operand magnitudes.
    always_comb begin
        w_sh      = bus.in_2[SHW-1:0];
        w_iter_op = (bus.op >= OP_MUL) && (bus.op <= OP_REMU);
        w_div_op  = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
        w_early   = 1'b0;
        w_imm     = '0;
        case (bus.op)
            OP_ADD:  w_imm = bus.in_1 + bus.in_2;
            OP_SUB:  w_imm = bus.in_1 - bus.in_2;
            OP_SLL:  w_imm = bus.in_1 << w_sh;
            OP_SLT:  w_imm[0] = ($signed(bus.in_1) < $signed(bus.in_2));
            OP_SLTU: w_imm[0] = (bus.in_1 < bus.in_2);
            OP_XOR:  w_imm = bus.in_1 ^ bus.in_2;
            OP_SRL:  w_imm = bus.in_1 >> w_sh;
            OP_SRA:  w_imm = $unsigned($signed(bus.in_1) >>> w_sh);
            OP_OR:   w_imm = bus.in_1 | bus.in_2;
            OP_AND:  w_imm = bus.in_1 & bus.in_2;
            default: w_imm = '0;
        endcase
        if (w_div_op && (bus.in_2 == '0)) begin
            w_early = 1'b1;
            w_imm   = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ? '1 : bus.in_1;
        end else if (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.in_1 == MOST_NEG) && (bus.in_2 == '1)) begin
            w_early = 1'b1;
            w_imm   = (bus.op == OP_DIV) ? bus.in_1 : '0;
        end
        w_sa = ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_REM)) && bus.in_1[WIDTH-1];
        w_sb = ((bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                (bus.op == OP_REM)) && bus.in_2[WIDTH-1];
        w_neg        = (bus.op == OP_REM) ? w_sa : (w_sa ^ w_sb);
        w_mag_1      = cond_neg(w_sa, bus.in_1);
        w_mag_2      = cond_neg(w_sb, bus.in_2);
        w_accept     = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
        w_start_busy = w_iter_op && !w_early;
    end

    // One multiply / divide iteration plus the signed final result.
    always_comb begin
        w_busy_mul = (r_op < OP_DIV);
        w_last     = (r_cnt == LAST_CNT);
        w_msum     = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
        w_macc     = w_msum[WIDTH:1];
        w_mmq      = {w_msum[0], r_b[WIDTH-1:1]};
        w_prod     = cond_neg2(r_neg, {w_macc, w_mmq});
        w_dsh      = {r_acc, r_b[WIDTH-1]};
        w_dge      = (w_dsh >= {1'b0, r_a});
        w_dsub     = w_dsh[WIDTH-1:0] - r_a;
        w_dacc     = w_dge ? w_dsub : w_dsh[WIDTH-1:0];
        w_dq       = {r_b[WIDTH-2:0], w_dge};
        case (r_op)
            OP_MUL:                       w_fin = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU: w_fin = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_fin = cond_neg(r_neg, w_dq);
            OP_REM, OP_REMU:              w_fin = cond_neg(r_neg, w_dacc);
            default:                      w_fin = '0;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: flush wins over everything, including a same-cycle request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_start_busy ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (bus.flush)   w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (bus.flush || bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_out  <= '0;
            r_zero <= 1'b1;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_cnt <= '0;
            if (w_start_busy) begin
                r_a   <= w_mag_2;
                r_b   <= w_mag_1;
                r_acc <= '0;
                r_neg <= w_neg;
            end else begin
                r_out  <= w_imm;
                r_zero <= (w_imm == '0);
            end
        end else if ((r_state == S_BUSY) && !bus.flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_busy_mul) begin
                r_acc <= w_macc;
                r_b   <= w_mmq;
            end else begin
                r_acc <= w_dacc;
                r_b   <= w_dq;
            end
            if (w_last) begin
                r_out  <= w_fin;
                r_zero <= (w_fin == '0);
            end
        end
    end

endmodule
